// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues one data-memory request per load/store, writes back 1 cycle
// after non-memops and 2+N cycles after memops; stall_mem holds upstream until dmem_resp arrives.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,

  input  logic        valid_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [4:0]  rd_mem,
  input  logic        load_regfile_mem,
  input  logic [3:0]  regfilemux_sel_mem,
  input  logic        data_read_mem,
  input  logic        data_write_mem,
  input  logic        br_en_mem,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] u_imm_mem,
  input  logic [31:0] pc_mem,
  input  logic [31:0] rs2_out_mem,

  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,

  output logic        stall_mem,

  output logic [4:0]  rd_wb,
  output logic        load_regfile_wb,
  output logic [31:0] regfilemux_out_wb
);

  localparam logic [3:0] SEL_ALU      = 4'd0;
  localparam logic [3:0] SEL_BR_EN    = 4'd1;
  localparam logic [3:0] SEL_U_IMM    = 4'd2;
  localparam logic [3:0] SEL_LW       = 4'd3;
  localparam logic [3:0] SEL_PC_PLUS4 = 4'd4;
  localparam logic [3:0] SEL_LB       = 4'd5;
  localparam logic [3:0] SEL_LBU      = 4'd6;
  localparam logic [3:0] SEL_LH       = 4'd7;
  localparam logic [3:0] SEL_LHU      = 4'd8;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  logic [31:0] dmem_address_q, dmem_address_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_byte_enable_q, dmem_byte_enable_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic        load_regfile_wb_q, load_regfile_wb_d;
  logic [31:0] regfilemux_out_wb_q, regfilemux_out_wb_d;

  logic        memop;
  logic [1:0]  off;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] mux_out;

  assign memop = valid_mem & (data_read_mem | data_write_mem);
  assign off   = alu_out_mem[1:0];

  assign stall_mem = ((state_q == IDLE) & memop) | ((state_q == WAIT) & ~dmem_resp);

  // Store lane placement from the byte offset of the effective address
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = rs2_out_mem;
    case (funct3_mem)
      3'b000: begin
        store_be    = 4'b0001 << off;
        store_wdata = rs2_out_mem << {off, 3'b000};
      end
      3'b001: begin
        store_be    = off[1] ? 4'b1100 : 4'b0011;
        store_wdata = off[1] ? {rs2_out_mem[15:0], 16'h0000} : rs2_out_mem;
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = rs2_out_mem;
      end
    endcase
  end

  // Load data is taken straight off the bus in the resp cycle and lands in the wb register
  assign ld_byte = dmem_rdata[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    mux_out = alu_out_mem;
    case (regfilemux_sel_mem)
      SEL_ALU:      mux_out = alu_out_mem;
      SEL_BR_EN:    mux_out = {31'b0, br_en_mem};
      SEL_U_IMM:    mux_out = u_imm_mem;
      SEL_LW:       mux_out = dmem_rdata;
      SEL_PC_PLUS4: mux_out = pc_mem + 32'd4;
      SEL_LB:       mux_out = {{24{ld_byte[7]}}, ld_byte};
      SEL_LBU:      mux_out = {24'b0, ld_byte};
      SEL_LH:       mux_out = {{16{ld_half[15]}}, ld_half};
      SEL_LHU:      mux_out = {16'b0, ld_half};
      default:      mux_out = alu_out_mem;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    dmem_read_d        = dmem_read_q;
    dmem_write_d       = dmem_write_q;
    dmem_address_d     = dmem_address_q;
    dmem_wdata_d       = dmem_wdata_q;
    dmem_byte_enable_d = dmem_byte_enable_q;
    case (state_q)
      IDLE: begin
        if (memop) begin
          state_d            = WAIT;
          dmem_read_d        = data_read_mem;
          dmem_write_d       = data_write_mem & ~data_read_mem;
          dmem_address_d     = {alu_out_mem[31:2], 2'b00};
          dmem_wdata_d       = store_wdata;
          dmem_byte_enable_d = data_read_mem ? 4'b1111 : store_be;
        end
      end
      WAIT: begin
        if (dmem_resp) begin
          state_d      = IDLE;
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_wb_d             = rd_wb_q;
    regfilemux_out_wb_d = regfilemux_out_wb_q;
    load_regfile_wb_d   = 1'b0;
    if (!stall_mem) begin
      rd_wb_d             = rd_mem;
      regfilemux_out_wb_d = mux_out;
      load_regfile_wb_d   = valid_mem & load_regfile_mem & (rd_mem != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      dmem_read_q        <= 1'b0;
      dmem_write_q       <= 1'b0;
      dmem_address_q     <= 32'h0;
      dmem_wdata_q       <= 32'h0;
      dmem_byte_enable_q <= 4'h0;
    end else begin
      state_q            <= state_d;
      dmem_read_q        <= dmem_read_d;
      dmem_write_q       <= dmem_write_d;
      dmem_address_q     <= dmem_address_d;
      dmem_wdata_q       <= dmem_wdata_d;
      dmem_byte_enable_q <= dmem_byte_enable_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_wb_q             <= 5'd0;
      load_regfile_wb_q   <= 1'b0;
      regfilemux_out_wb_q <= 32'h0;
    end else begin
      rd_wb_q             <= rd_wb_d;
      load_regfile_wb_q   <= load_regfile_wb_d;
      regfilemux_out_wb_q <= regfilemux_out_wb_d;
    end
  end

  assign dmem_read         = dmem_read_q;
  assign dmem_write        = dmem_write_q;
  assign dmem_address      = dmem_address_q;
  assign dmem_wdata        = dmem_wdata_q;
  assign dmem_byte_enable  = dmem_byte_enable_q;
  assign rd_wb             = rd_wb_q;
  assign load_regfile_wb   = load_regfile_wb_q;
  assign regfilemux_out_wb = regfilemux_out_wb_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: behavioural data memory with programmable response delay,
// scoreboard of expected register-file writes popped whenever load_regfile_wb fires.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_mem = 1'b0;
  logic [2:0]  funct3_mem = 3'd0;
  logic [4:0]  rd_mem = 5'd0;
  logic        load_regfile_mem = 1'b0;
  logic [3:0]  regfilemux_sel_mem = 4'd0;
  logic        data_read_mem = 1'b0;
  logic        data_write_mem = 1'b0;
  logic        br_en_mem = 1'b0;
  logic [31:0] alu_out_mem = 32'h0;
  logic [31:0] u_imm_mem = 32'h0;
  logic [31:0] pc_mem = 32'h0;
  logic [31:0] rs2_out_mem = 32'h0;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_resp = 1'b0;
  logic        stall_mem;
  logic [4:0]  rd_wb;
  logic        load_regfile_wb;
  logic [31:0] regfilemux_out_wb;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .valid_mem(valid_mem), .funct3_mem(funct3_mem), .rd_mem(rd_mem),
    .load_regfile_mem(load_regfile_mem), .regfilemux_sel_mem(regfilemux_sel_mem),
    .data_read_mem(data_read_mem), .data_write_mem(data_write_mem), .br_en_mem(br_en_mem),
    .alu_out_mem(alu_out_mem), .u_imm_mem(u_imm_mem), .pc_mem(pc_mem), .rs2_out_mem(rs2_out_mem),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .stall_mem(stall_mem),
    .rd_wb(rd_wb), .load_regfile_wb(load_regfile_wb), .regfilemux_out_wb(regfilemux_out_wb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Reference writeback value, with explicit byte/half picks
  function automatic logic [31:0] model(input logic [3:0] sel, input logic [31:0] alu,
                                        input logic [31:0] u, input logic [31:0] pc,
                                        input logic br, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (alu[1:0])
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = alu[1] ? word[31:16] : word[15:0];
    case (sel)
      4'd1:    return {31'b0, br};
      4'd2:    return u;
      4'd3:    return word;
      4'd4:    return pc + 32'd4;
      4'd5:    return {{24{b[7]}}, b};
      4'd6:    return {24'b0, b};
      4'd7:    return {{16{h[15]}}, h};
      4'd8:    return {16'b0, h};
      default: return alu;
    endcase
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory responder
  int          resp_delay = 1;
  bit          mem_en = 1'b1;
  bit          force_resp = 1'b0;
  int          cnt = 0;
  int          req_cycles = 0;
  int          req_start = 0;
  int          last_resp_cyc = -1;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;

  always @(negedge clk) begin
    logic [31:0] w;
    if (!mem_en) begin
      dmem_resp = force_resp;
      cnt = 0;
    end else if (rst && (dmem_read || dmem_write)) begin
      if (cnt == 0) begin
        req_addr = dmem_address; req_wdata = dmem_wdata; req_be = dmem_byte_enable;
        req_rd = dmem_read; req_wr = dmem_write; req_cycles = 1; req_start = cyc;
      end else begin
        chk("hold_addr", dmem_address, req_addr);
        chk("hold_wdata", dmem_wdata, req_wdata);
        chk("hold_ctl", {26'b0, dmem_byte_enable, dmem_read, dmem_write},
            {26'b0, req_be, req_rd, req_wr});
        req_cycles++;
      end
      if (cnt == resp_delay) begin
        dmem_resp = 1'b1;
        dmem_rdata = mem_word(req_addr);
        last_resp_cyc = cyc;
        if (dmem_write) begin
          w = mem_word(req_addr);
          for (int k = 0; k < 4; k++)
            if (dmem_byte_enable[k]) w[8*k +: 8] = dmem_wdata[8*k +: 8];
          mem[req_addr] = w;
        end
      end else begin
        dmem_resp = 1'b0;
      end
      cnt++;
    end else begin
      dmem_resp = 1'b0;
      cnt = 0;
    end
  end

  // Writeback monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst && load_regfile_wb) begin
      if (sbq.size() == 0) begin
        chk("wb_unexpected", {31'b0, load_regfile_wb}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("wb_rd", {27'b0, rd_wb}, {27'b0, e.rd});
        chk("wb_data", regfilemux_out_wb, e.data);
      end
    end
  end

  int stall_cycles = 0;

  task automatic send(input logic v, input logic [2:0] f3, input logic [4:0] rd, input logic ld,
                      input logic [3:0] sel, input logic rdm, input logic wrm, input logic br,
                      input logic [31:0] alu, input logic [31:0] u, input logic [31:0] pc,
                      input logic [31:0] rs2);
    exp_t e;
    valid_mem = v; funct3_mem = f3; rd_mem = rd; load_regfile_mem = ld;
    regfilemux_sel_mem = sel; data_read_mem = rdm; data_write_mem = wrm; br_en_mem = br;
    alu_out_mem = alu; u_imm_mem = u; pc_mem = pc; rs2_out_mem = rs2;
    if (v && ld && rd != 5'd0) begin
      e.rd = rd;
      e.data = model(sel, alu, u, pc, br, mem_word({alu[31:2], 2'b00}));
      sbq.push_back(e);
    end
    stall_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (!stall_mem) break;
      stall_cycles++;
    end
    if (stall_cycles >= 60) chk("stall_timeout", {31'b0, stall_mem}, 32'h0);
    @(posedge clk); #1;
    valid_mem = 1'b0; data_read_mem = 1'b0; data_write_mem = 1'b0; load_regfile_mem = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r1;
    mem[32'h1000] = 32'h0080_0000;
    mem[32'h3000] = 32'h8001_F00F;
    mem[32'h0100] = 32'h1111_1111;
    mem[32'h0104] = 32'h2222_2222;

    #2;
    chk("rst_read", {31'b0, dmem_read}, 32'h0);
    chk("rst_write", {31'b0, dmem_write}, 32'h0);
    chk("rst_addr", dmem_address, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_be", {28'b0, dmem_byte_enable}, 32'h0);
    chk("rst_rd_wb", {27'b0, rd_wb}, 32'h0);
    chk("rst_load_wb", {31'b0, load_regfile_wb}, 32'h0);
    chk("rst_out_wb", regfilemux_out_wb, 32'h0);
    chk("rst_stall", {31'b0, stall_mem}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // ALU writeback
    send(1, 3'd0, 5'd5, 1, 4'd0, 0, 0, 0, 32'h1234, 32'h0, 32'h0, 32'h0);
    chk("alu_stall", stall_cycles, 0);
    chk("alu_rd", {27'b0, rd_wb}, 32'd5);
    chk("alu_ld", {31'b0, load_regfile_wb}, 32'h1);
    chk("alu_out", regfilemux_out_wb, 32'h1234);

    // lb with 3 wait cycles
    resp_delay = 3;
    send(1, 3'b000, 5'd7, 1, 4'd5, 1, 0, 0, 32'h1002, 32'h0, 32'h0, 32'h0);
    chk("lb_addr", req_addr, 32'h1000);
    chk("lb_read_cycles", req_cycles, 4);
    chk("lb_stall", stall_cycles, 4);
    chk("lb_be", {28'b0, req_be}, 32'hF);
    chk("lb_out", regfilemux_out_wb, 32'hFFFF_FF80);
    @(negedge clk); #1;
    chk("lb_read_clear", {31'b0, dmem_read}, 32'h0);

    // sh, sb, sw stores
    resp_delay = 2;
    send(1, 3'b001, 5'd9, 0, 4'd0, 0, 1, 0, 32'h2002, 32'h0, 32'h0, 32'h0000_BEEF);
    chk("sh_be", {28'b0, req_be}, 32'hC);
    chk("sh_wdata", req_wdata, 32'hBEEF_0000);
    chk("sh_ctl", {30'b0, req_rd, req_wr}, 32'h1);
    chk("sh_cycles", req_cycles, 3);
    chk("sh_ld", {31'b0, load_regfile_wb}, 32'h0);
    resp_delay = 0;
    send(1, 3'b000, 5'd9, 0, 4'd0, 0, 1, 0, 32'h2003, 32'h0, 32'h0, 32'h1234_5678);
    chk("sb_be", {28'b0, req_be}, 32'h8);
    chk("sb_wdata", req_wdata, 32'h7800_0000);
    chk("sb_stall", stall_cycles, 1);
    send(1, 3'b010, 5'd9, 0, 4'd0, 0, 1, 0, 32'h4001, 32'h0, 32'h0, 32'hCAFE_BABE);
    chk("sw_addr", req_addr, 32'h4000);
    chk("sw_be", {28'b0, req_be}, 32'hF);
    chk("sw_wdata", req_wdata, 32'hCAFE_BABE);

    // Loads of various widths, including read+write treated as read
    resp_delay = 1;
    send(1, 3'b100, 5'd10, 1, 4'd6, 1, 0, 0, 32'h2003, 32'h0, 32'h0, 32'h0);
    chk("lbu_out", regfilemux_out_wb, 32'h0000_0078);
    send(1, 3'b001, 5'd11, 1, 4'd7, 1, 0, 0, 32'h2002, 32'h0, 32'h0, 32'h0);
    chk("lh_pos_out", regfilemux_out_wb, 32'h0000_78EF);
    send(1, 3'b001, 5'd12, 1, 4'd7, 1, 0, 0, 32'h3000, 32'h0, 32'h0, 32'h0);
    chk("lh_neg_out", regfilemux_out_wb, 32'hFFFF_F00F);
    send(1, 3'b101, 5'd13, 1, 4'd8, 1, 1, 0, 32'h3002, 32'h0, 32'h0, 32'h0);
    chk("rw_is_read", {30'b0, req_rd, req_wr}, 32'h2);
    chk("rw_be", {28'b0, req_be}, 32'hF);
    chk("lhu_out", regfilemux_out_wb, 32'h0000_8001);
    send(1, 3'b010, 5'd14, 1, 4'd3, 1, 0, 0, 32'h3003, 32'h0, 32'h0, 32'h0);
    chk("lw_mis_out", regfilemux_out_wb, 32'h8001_F00F);

    // x0, pc_plus4 wrap, br_en, u_imm, out-of-range select
    send(1, 3'd0, 5'd0, 1, 4'd0, 0, 0, 0, 32'h99, 32'h0, 32'h0, 32'h0);
    chk("x0_ld", {31'b0, load_regfile_wb}, 32'h0);
    chk("x0_rd", {27'b0, rd_wb}, 32'h0);
    send(1, 3'd0, 5'd3, 1, 4'd4, 0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    chk("pc4_out", regfilemux_out_wb, 32'h0);
    send(1, 3'd0, 5'd4, 1, 4'd1, 0, 0, 1, 32'h55, 32'h0, 32'h0, 32'h0);
    send(1, 3'd0, 5'd6, 1, 4'd2, 0, 0, 0, 32'h55, 32'hABCD_E000, 32'h0, 32'h0);
    send(1, 3'd0, 5'd8, 1, 4'd13, 0, 0, 0, 32'h0BAD_F00D, 32'h1, 32'h0, 32'h0);
    send(0, 3'd0, 5'd8, 1, 4'd0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 32'h0);
    chk("invalid_ld", {31'b0, load_regfile_wb}, 32'h0);

    // Back-to-back loads
    resp_delay = 1;
    send(1, 3'b010, 5'd20, 1, 4'd3, 1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0);
    r1 = last_resp_cyc;
    send(1, 3'b010, 5'd21, 1, 4'd3, 1, 0, 0, 32'h104, 32'h0, 32'h0, 32'h0);
    chk("b2b_addr2", req_addr, 32'h104);
    chk("b2b_order", {31'b0, req_start > r1}, 32'h1);
    chk("b2b_out2", regfilemux_out_wb, 32'h2222_2222);

    // Reset in the middle of WAIT
    mem_en = 1'b0;
    valid_mem = 1'b1; funct3_mem = 3'b010; rd_mem = 5'd4; load_regfile_mem = 1'b1;
    regfilemux_sel_mem = 4'd3; data_read_mem = 1'b1; alu_out_mem = 32'h500;
    @(negedge clk); #1;
    chk("rw_stall_idle", {31'b0, stall_mem}, 32'h1);
    repeat (3) @(negedge clk);
    #1;
    chk("rw_read_wait", {31'b0, dmem_read}, 32'h1);
    chk("rw_addr_wait", dmem_address, 32'h500);
    rst = 1'b0; valid_mem = 1'b0; data_read_mem = 1'b0; load_regfile_mem = 1'b0;
    #1;
    chk("rw_read_rst", {31'b0, dmem_read}, 32'h0);
    chk("rw_stall_rst", {31'b0, stall_mem}, 32'h0);
    chk("rw_addr_rst", dmem_address, 32'h0);
    chk("rw_out_rst", regfilemux_out_wb, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    force_resp = 1'b1;
    @(negedge clk); #1;
    force_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("late_resp_ld", {31'b0, load_regfile_wb}, 32'h0);
      chk("late_resp_read", {31'b0, dmem_read}, 32'h0);
    end

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous, active-low reset.
REQ-002 SHALL have upstream inputs: valid_mem 1; funct3_mem 3; rd_mem 5; load_regfile_mem 1; regfilemux_sel_mem 4; data_read_mem 1; data_write_mem 1; br_en_mem 1.
REQ-003 SHALL have upstream data inputs, each 32 bits: alu_out_mem (result/address), u_imm_mem, pc_mem, rs2_out_mem (store data).
REQ-004 SHALL use regfilemux_sel encoding: alu_out=0, br_en=1, u_imm=2, lw=3, pc_plus4=4, lb=5, lbu=6, lh=7, lhu=8; values 9-15 select alu_out.
REQ-005 SHALL have memory ports: dmem_address out 32; dmem_read out 1; dmem_write out 1; dmem_wdata out 32; dmem_byte_enable out 4; dmem_rdata in 32; dmem_resp in 1.
REQ-006 SHALL have stall_mem out 1, which holds every upstream stage while high.
REQ-007 SHALL have writeback outputs to the decode-stage register file: rd_wb out 5; load_regfile_wb out 1; regfilemux_out_wb out 32.

Function
REQ-008 SHALL define a memop as valid_mem & (data_read_mem | data_write_mem).
REQ-009 SHALL treat data_read_mem=data_write_mem=1 as a read.
REQ-010 SHALL implement an FSM with two states, IDLE and WAIT.
REQ-011 SHALL, when IDLE with a memop at a clock edge, register dmem_read/dmem_write, dmem_address={alu_out_mem[31:2],2'b00}, dmem_wdata and dmem_byte_enable, then enter WAIT; the request is visible 1 cycle after the memop is presented.
REQ-012 SHALL, in WAIT, hold every dmem_* output stable until dmem_resp=1.
REQ-013 SHALL, on dmem_resp=1 in WAIT, capture dmem_rdata, clear dmem_read/dmem_write at the next edge and return to IDLE.
REQ-014 SHALL make stall_mem combinational: 1 when (IDLE & memop) or (WAIT & ~dmem_resp), else 0.
REQ-015 SHALL ignore dmem_resp while IDLE.
REQ-016 SHALL, for a store, drive byte_enable and wdata from off=alu_out_mem[1:0]:
  - funct3 000 (sb): be=4'b0001<<off, wdata=rs2_out_mem<<(8*off);
  - funct3 001 (sh): be=4'b0011<<(2*off[1]), wdata=rs2_out_mem<<(16*off[1]);
  - otherwise (sw): be=4'b1111, wdata=rs2_out_mem.
REQ-017 SHALL drive dmem_byte_enable=4'b1111 for a load.
REQ-018 SHALL extract load data from the captured rdata using the same off:
  - lb/lbu: byte off, sign-/zero-extended;
  - lh/lhu: halfword off[1], sign-/zero-extended;
  - lw: full word; misaligned low bits are ignored.
REQ-019 SHALL mux sources as: alu_out=alu_out_mem; br_en={31'b0,br_en_mem}; u_imm=u_imm_mem; pc_plus4=pc_mem+4, modulo 2^32.
REQ-020 SHALL update the writeback register only on edges where stall_mem=0: rd_wb<=rd_mem, regfilemux_out_wb<=mux result, load_regfile_wb<=valid_mem & load_regfile_mem & (rd_mem!=0).
REQ-021 SHALL load load_regfile_wb<=0 on an edge where stall_mem=1, inserting a bubble; rd_wb and regfilemux_out_wb hold.
REQ-022 SHALL make load data reach regfilemux_out_wb at the edge that ends the dmem_resp cycle.
REQ-023 SHALL have writeback latency of 1 cycle for non-memop instructions and 2+N cycles for memops, N being the number of WAIT cycles before dmem_resp.
REQ-024 SHALL present a stores' writeback entry with load_regfile_wb=0, since load_regfile_mem=0 for stores.

Reset
REQ-025 SHALL, while rst=0, immediately force state=IDLE and all registered outputs to 0, including dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, rd_wb, load_regfile_wb and regfilemux_out_wb.
REQ-026 SHALL abandon an outstanding request on reset mid-WAIT; a late dmem_resp after reset is ignored.
REQ-027 SHALL resume normal operation at the first rising edge after rst returns to 1.

Verification
REQ-028 SHALL verify ALU writeback: valid, rd=5, sel=alu_out, alu_out=0x1234 -> next cycle rd_wb=5, load_regfile_wb=1, regfilemux_out_wb=0x1234, stall_mem=0 throughout.
REQ-029 SHALL verify lb with a wait: alu_out=0x1002, sel=lb, dmem_resp after 3 WAIT cycles with rdata=0x00800000 -> dmem_address=0x1000 and dmem_read=1 for 4 cycles, stall_mem=1 until resp, then regfilemux_out_wb=0xFFFFFF80, load_regfile_wb=1 once.
REQ-030 SHALL verify sh: alu_out=0x2002, rs2=0x0000BEEF, funct3=001 -> be=4'b1100, wdata=0xBEEF0000, dmem_write held until resp, load_regfile_wb=0.
REQ-031 SHALL verify x0 and pc_plus4: rd=0 -> load_regfile_wb=0; sel=pc_plus4, pc=0xFFFFFFFC -> regfilemux_out_wb=0x00000000.
REQ-032 SHALL verify reset mid-WAIT: drive rst=0 while in WAIT -> dmem_read=0 and stall_mem=0 immediately; a later dmem_resp=1 produces no writeback.
REQ-033 SHALL verify back-to-back loads lw 0x100 then lw 0x104 -> second request issues only after the first resp, and both writebacks appear in program order.
